alu_muldiv_ctrl: RTL
====================

# alu_muldiv_ctrl

ALU control unit for the single-cycle datapath, extended to handle multi-cycle operations. It decodes `ALUop` and the R-type funct field into the 4-bit ALU function code, exactly as the current control path does. For MUL and DIV it also runs a parametrised iterative signed multiplier/divider, stalling the pipeline until the result is ready. It sits between the main control unit and the ALU/writeback mux.

## Interface
- `WIDTH`, 32, operand and result width in bits (≥4).
- `CNT_W`, $clog2(WIDTH), iteration counter width.
- `clk  in  1  ` system clock; all state changes on the rising edge.
- `reset  in  1  ` asynchronous, active-high reset.
- `instruction  in  32  ` current instruction; only [5:0] (funct) is used.
- `ALUop  in  2  ` from main control.
- `issue  in  1  ` instruction in decode is valid this cycle.
- `a  in  WIDTH  ` rs operand (dividend / multiplicand).
- `b  in  WIDTH  ` rt operand (divisor / multiplier).
- `func_out  out  4  ` ALU function code (combinational).
- `stall  out  1  ` freeze PC and pipeline (combinational).
- `busy  out  1  ` iterative unit is in RUN.
- `done  out  1  ` one-cycle pulse; the result is valid.
- `result_out  out  WIDTH  ` MUL low word / DIV quotient.
- `hi_out  out  WIDTH  ` MUL high word / DIV remainder.
- `div_by_zero  out  1  ` set together with `done` for a DIV whose `b` was 0.

## Operation
- **Decode (`func_out`)**, combinational and independent of state:
  - `ALUop` 00 (LW/SW) → 0010.
  - `ALUop` 01 (BEQ/BNE) → 0110.
  - `ALUop` 11 (ADDI) → 0010.
  - `ALUop` 10, by funct: 100000 ADD → 0010; 100010 SUB → 0110; 011010 DIV → 1010; 011000 MUL → 1001; 101010 SLT → 0111; 100100 AND → 0000; 100101 OR → 0001; 100111 NOR → 1100; any other funct → 0000.
- `is_md` = `ALUop`==10 and funct is 011000 or 011010.
- **States:** IDLE, RUN, DONE.
  - IDLE → RUN when `issue & is_md`.
    - Latch `|a|`, `|b|`, the result sign(s), the op (MUL/DIV), and `b==0`.
    - Load the counter with WIDTH-1.
  - RUN: one shift-add (MUL) or restoring-subtract (DIV) step per cycle; the counter decrements. Go to DONE when the counter is 0 after a step.
  - DONE → IDLE unconditionally. `issue` is ignored in DONE.
- **Arithmetic:** signed two's complement, using sign-magnitude iteration on WIDTH-bit magnitudes with a 2·WIDTH accumulator.
  - MUL: {`hi_out`,`result_out`} = the full signed 2·WIDTH product.
  - DIV: quotient truncates toward zero; the remainder takes the sign of the dividend.
  - DIV of the most-negative value by -1: quotient = most-negative value (wraps), remainder = 0.
  - DIV by zero: runs the full latency. Result is `result_out`={WIDTH{1}}, `hi_out`=`a` as latched, and `div_by_zero`=1.
- `result_out`, `hi_out` and `div_by_zero` are registered. They update on entry to DONE and hold until the next entry to DONE.
- Non-MUL/DIV instructions never leave IDLE and never stall.

## Timing
- **Reset:** state IDLE, counter 0, and `busy`, `done`, `result_out`, `hi_out`, `div_by_zero` all 0. The async assert takes effect immediately.
- **Reset during RUN:** aborts the operation. `done` never pulses and the old result is discarded (zeroed).
- **`stall`** = `busy` | (state==IDLE & `issue` & `is_md`). It is 0 in DONE.
- **Latency:** accept in cycle T, RUN in cycles T+1..T+WIDTH, DONE (`done`=1) in cycle T+WIDTH+1.
  - `stall` is high for WIDTH+1 cycles (T..T+WIDTH).
  - The pipeline consumes the result in the DONE cycle.
- **Back-to-back MUL/DIV:** the second one is accepted no earlier than T+WIDTH+2. The minimum issue spacing is WIDTH+2 cycles.
- **Operand stability:** `a` and `b` are sampled only in the accept cycle. Changes during RUN have no effect.
- **`busy`** = (state==RUN), registered.

## Test plan
- **Reset and decode:**
  - Assert `reset` mid-cycle → all outputs 0 immediately.
  - Sweep every `ALUop` and funct from the decode list, plus funct 000000 → `func_out` matches the list and `stall`=0 for all of them.
- **MUL, WIDTH=32:**
  - `a`=-7 (0xFFFFFFF9), `b`=6, issue at T → `stall` high T..T+32, `done` at T+33, `result_out`=0xFFFFFFD6, `hi_out`=0xFFFFFFFF.
  - `a`=0x80000000, `b`=0x80000000 → `hi_out`=0x40000000, `result_out`=0.
- **DIV:**
  - `a`=-17, `b`=5 → `result_out`=-3 (0xFFFFFFFD), `hi_out`=-2 (0xFFFFFFFE), `div_by_zero`=0.
  - `a`=0x80000000, `b`=-1 → `result_out`=0x80000000, `hi_out`=0.
- **Divide by zero:** `a`=123, `b`=0 → `done` at T+33, `result_out`=0xFFFFFFFF, `hi_out`=123, `div_by_zero`=1.
- **Reset during RUN:** assert `reset` at T+10 → no `done` pulse, outputs 0; a fresh MUL 3×4 issued after release → `result_out`=12 after 33 cycles.
- **Back-to-back and operand changes:**
  - Two MULs issued back-to-back with `issue` held high → the second is accepted at T+34, with exactly one `done` per operation.
  - Toggle `a` and `b` during RUN → result unaffected.
  - With WIDTH=8: MUL 5×-3 → `done` at T+9, `result_out`=0xF1, `hi_out`=0xFF.

Source files
------------

// File: rtl/alu_muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// alu_muldiv_ctrl
//
// ALU control for the single-cycle datapath, extended with an iterative signed
// multiplier/divider. The ALU function code is decoded combinationally from
// ALUop and the R-type funct field. MUL and DIV launch a WIDTH-step
// sign-magnitude iteration (shift-add for MUL, restoring subtract for DIV).
// The pipeline is stalled from the accept cycle until the DONE cycle, in which
// the result is consumed.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   instruction  current instruction, only [5:0] (funct) is decoded
//   ALUop        operation class from main control
//   issue        decode-stage instruction is valid
//   a, b         rs / rt operands (dividend, multiplicand / divisor, multiplier)
//   func_out     4-bit ALU function code (combinational)
//   stall        freeze PC and pipeline (combinational)
//   busy         iterative unit is in RUN (registered)
//   done         one-cycle pulse, result valid
//   result_out   MUL low word / DIV quotient
//   hi_out       MUL high word / DIV remainder
//   div_by_zero  DIV with zero divisor, qualifies done
// -----------------------------------------------------------------------------
module alu_muldiv_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instruction,
  input  logic [1:0]       ALUop,
  input  logic             issue,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [3:0]       func_out,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_out,
  output logic [WIDTH-1:0] hi_out,
  output logic             div_by_zero
);

  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic [5:0] funct;
  logic       is_md;
  logic       accept;
  logic       unused_instr;

  // Operands latched at accept time
  logic             op_div;
  logic             neg_lo;   // sign of product / quotient
  logic             neg_hi;   // sign of remainder (dividend sign)
  logic             dbz_lat;
  logic [WIDTH-1:0] opnd;     // |a| for MUL, |b| for DIV
  logic [W2-1:0]    acc;      // {hi, lo}: MUL {partial, multiplier}, DIV {rem, quotient}

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic [W2-1:0]    step_acc;
  logic [W2-1:0]    prod;
  logic [WIDTH-1:0] fin_lo;
  logic [WIDTH-1:0] fin_hi;

  // Magnitude of a two's-complement value; the most-negative value maps to
  // 2^(WIDTH-1), which still fits as an unsigned WIDTH-bit magnitude.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                  input logic neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [W2-1:0] apply_sign2(input logic [W2-1:0] v,
                                                input logic neg);
    return neg ? (~v + W2'(1)) : v;
  endfunction

  assign funct        = instruction[5:0];
  assign unused_instr = ^instruction[31:6];

  always_comb begin
    func_out = 4'b0000;
    case (ALUop)
      2'b00: func_out = 4'b0010;
      2'b01: func_out = 4'b0110;
      2'b11: func_out = 4'b0010;
      default: begin
        case (funct)
          6'b100000: func_out = 4'b0010;
          6'b100010: func_out = 4'b0110;
          6'b011010: func_out = 4'b1010;
          6'b011000: func_out = 4'b1001;
          6'b101010: func_out = 4'b0111;
          6'b100100: func_out = 4'b0000;
          6'b100101: func_out = 4'b0001;
          6'b100111: func_out = 4'b1100;
          default:   func_out = 4'b0000;
        endcase
      end
    endcase
  end

  assign is_md  = (ALUop == 2'b10) && ((funct == 6'b011000) || (funct == 6'b011010));
  assign accept = (state == S_IDLE) && issue && is_md;
  assign stall  = busy | accept;

  // One iteration step on the accumulator
  always_comb begin
    mul_sum   = {1'b0, acc[W2-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    div_shift = {acc[W2-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd};
    if (op_div) begin
      // No borrow means the divisor fits: keep the difference, quotient bit 1
      if (!div_diff[WIDTH])
        step_acc = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
        step_acc = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      step_acc = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  // Signed result from the final step. With a zero divisor every restoring
  // step succeeds, leaving |a| in the remainder, so re-signing it yields a.
  always_comb begin
    prod = apply_sign2(step_acc, neg_lo);
    if (op_div) begin
      fin_lo = dbz_lat ? {WIDTH{1'b1}} : apply_sign(step_acc[WIDTH-1:0], neg_lo);
      fin_hi = apply_sign(step_acc[W2-1:WIDTH], neg_hi);
    end else begin
      fin_lo = prod[WIDTH-1:0];
      fin_hi = prod[W2-1:WIDTH];
    end
  end

  // Datapath registers: no reset, only meaningful between accept and DONE
  always_ff @(posedge clk) begin
    if (accept) begin
      op_div  <= funct[1];
      neg_lo  <= a[WIDTH-1] ^ b[WIDTH-1];
      neg_hi  <= a[WIDTH-1];
      dbz_lat <= funct[1] && (b == '0);
      opnd    <= funct[1] ? mag(b) : mag(a);
      acc     <= {{WIDTH{1'b0}}, (funct[1] ? mag(a) : mag(b))};
    end else if (state == S_RUN) begin
      acc     <= step_acc;
    end
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result_out  <= '0;
      hi_out      <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (accept) begin
            state <= S_RUN;
            cnt   <= CNT_W'(WIDTH - 1);
            busy  <= 1'b1;
          end
        end
        S_RUN: begin
          if (cnt == '0) begin
            state       <= S_DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            result_out  <= fin_lo;
            hi_out      <= fin_hi;
            div_by_zero <= op_div & dbz_lat;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_DONE: begin
          // issue is ignored here; a new operation starts from IDLE
          state <= S_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
